// File: rtl/systolic_feed_unit.sv
// Systolic feed unit: buffers K operand beats (one N-lane A vector and one
// N-lane B vector each) and replays them into an N x N PE array with a
// diagonal skew: lane i runs i cycles behind lane 0. It also drives the
// accumulator-clear and completion pulses, and honours the scheduler pause
// that the PE array shares.
module systolic_feed_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 4,
  parameter int K          = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pause,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  acc_keep,
  input  logic [N*DATA_WIDTH-1:0] in_left,
  input  logic [N*DATA_WIDTH-1:0] in_top,
  output logic [N*DATA_WIDTH-1:0] left_data,
  output logic [N-1:0]          left_valid,
  output logic [N*DATA_WIDTH-1:0] top_data,
  output logic [N-1:0]          top_valid,
  output logic                  clear_acc,
  output logic                  busy,
  output logic                  matmul_done
);

  // Final RUN step. The last element reaches PE(N-1,N-1) at this step.
  localparam int LAST_STEP = K + 2*N - 3;
  localparam int STEP_W    = ($clog2(K + 2*N - 1) > 0) ? $clog2(K + 2*N - 1) : 1;
  localparam int IDX_W     = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  state_t            state, state_next;
  logic [STEP_W-1:0] step, step_next;
  logic [IDX_W-1:0]  load_idx, load_idx_next;
  logic              acc_keep_q, acc_keep_next;
  logic              accept;

  // Each entry holds one whole beat. Lane i sits at [i*DATA_WIDTH +: DATA_WIDTH].
  logic [N*DATA_WIDTH-1:0] buf_left [K];
  logic [N*DATA_WIDTH-1:0] buf_top  [K];

  assign accept = in_valid && in_ready;

  // Beats are accepted only while loading and not stalled by the scheduler.
  always_comb begin
    in_ready = 1'b0;
    if (!pause && (state == IDLE || state == LOAD)) begin
      in_ready = 1'b1;
    end
  end

  // Next-state logic. Holding every register by default makes a pause freeze the block.
  always_comb begin
    state_next    = state;
    step_next     = step;
    load_idx_next = load_idx;
    acc_keep_next = acc_keep_q;
    if (!pause) begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc_keep_next = acc_keep;
            if (K == 1) begin
              state_next    = RUN;
              step_next     = '0;
              load_idx_next = '0;
            end else begin
              state_next    = LOAD;
              load_idx_next = IDX_W'(1);
            end
          end
        end
        LOAD: begin
          if (accept) begin
            if (load_idx == IDX_W'(K - 1)) begin
              state_next    = RUN;
              step_next     = '0;
              load_idx_next = '0;
            end else begin
              load_idx_next = load_idx + IDX_W'(1);
            end
          end
        end
        RUN: begin
          if (step == STEP_W'(LAST_STEP)) begin
            state_next = DONE;
          end else begin
            step_next = step + STEP_W'(1);
          end
        end
        DONE: begin
          state_next = IDLE;
          step_next  = '0;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Control registers. A reset discards any partial operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      step       <= '0;
      load_idx   <= '0;
      acc_keep_q <= 1'b0;
    end else begin
      state      <= state_next;
      step       <= step_next;
      load_idx   <= load_idx_next;
      acc_keep_q <= acc_keep_next;
    end
  end

  // Operand buffer. load_idx is 0 in IDLE, so the first beat lands in entry 0.
  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      buf_left[load_idx] <= in_left;
      buf_top[load_idx]  <= in_top;
    end
  end

  // Skewed lane outputs. rel = step - lane wraps to a large value before the
  // lane starts, so a single "rel < K" test covers both window edges.
  for (genvar g = 0; g < N; g++) begin : g_lane
    localparam logic [STEP_W-1:0] FIRST = STEP_W'(g);

    logic [STEP_W-1:0] rel;
    logic [IDX_W-1:0]  row;
    logic              lane_on;

    assign rel     = step - FIRST;
    assign row     = IDX_W'(rel);
    assign lane_on = (state == RUN) && (rel < STEP_W'(K));

    assign left_valid[g] = lane_on;
    assign top_valid[g]  = lane_on;
    assign left_data[g*DATA_WIDTH +: DATA_WIDTH] =
      lane_on ? buf_left[row][g*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign top_data[g*DATA_WIDTH +: DATA_WIDTH] =
      lane_on ? buf_top[row][g*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  assign busy        = (state != IDLE);
  assign clear_acc   = (state == RUN) && (step == '0) && !acc_keep_q;
  assign matmul_done = (state == DONE);

endmodule
